// File: rtl/pixel_chunk_packer.sv
// Packs rasterizer pixel writes into aligned CHUNK_PIXELS-wide write bursts with byte strobes.
// Optional idle auto-flush is enabled by defining PACKER_IDLE_FLUSH_EN.
module pixel_chunk_packer #(
    parameter int HRES         = 1280,
    parameter int VRES         = 720,
    parameter int PIXEL_WIDTH  = 16,
    parameter int CHUNK_PIXELS = 8,
    parameter int IDLE_CYCLES  = 64,
    localparam int AW  = $clog2(HRES * VRES),
    localparam int CW  = $clog2(CHUNK_PIXELS),
    localparam int DW  = CHUNK_PIXELS * PIXEL_WIDTH,
    localparam int SW  = CHUNK_PIXELS * PIXEL_WIDTH / 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [AW-1:0]    addr_in,
    input  logic [PIXEL_WIDTH-1:0] data_in,
    input  logic             strobe_in,
    input  logic             flush_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [AW-CW-1:0] addr_out,
    output logic [DW-1:0]    data_out,
    output logic [SW-1:0]    strobe_out,
    output logic             busy_out
);

    localparam int BPP = PIXEL_WIDTH / 8;

    if ((PIXEL_WIDTH % 8) != 0 || CHUNK_PIXELS < 2 ||
        (1 << CW) != CHUNK_PIXELS || IDLE_CYCLES < 1) begin : g_bad_params
        $error("pixel_chunk_packer: illegal parameter combination");
    end

    logic [AW-CW-1:0]        chunk_in;
    logic [CW-1:0]           slot_in;
    logic [AW-CW-1:0]        open_addr_q, open_addr_d;
    logic [DW-1:0]           data_q, data_d, merged_data, fresh_data;
    logic [CHUNK_PIXELS-1:0] strb_q, strb_d, merged_strb, fresh_strb;
    logic                    valid_q, valid_d;
    logic [AW-CW-1:0]        oaddr_q, oaddr_d;
    logic [DW-1:0]           odata_q, odata_d;
    logic [CHUNK_PIXELS-1:0] ostrb_q, ostrb_d;
    logic                    free, accept, open, full, same, new_chunk, close, idle_hit;

    assign chunk_in  = addr_in[AW-1:CW];
    assign slot_in   = addr_in[CW-1:0];
    assign free      = !valid_q || ready_in;
    assign accept    = valid_in && free;
    assign open      = |strb_q;
    assign full      = &strb_q;
    assign same      = (chunk_in == open_addr_q);
    assign new_chunk = accept && !same;
    assign close     = open && free && (new_chunk || flush_in || full || idle_hit);

`ifdef PACKER_IDLE_FLUSH_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;

    assign idle_hit = (idle_q >= IW'(IDLE_CYCLES));

    always_comb begin
        idle_d = idle_q;
        if (accept || close) begin
            idle_d = '0;
        end else if (open && !idle_hit) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign idle_hit = 1'b0;
`endif

    // merged_*: open chunk plus this cycle's pixel; fresh_*: this cycle's pixel alone
    always_comb begin
        merged_data = data_q;
        merged_strb = strb_q;
        fresh_data  = '0;
        fresh_strb  = '0;
        if (accept && strobe_in) begin
            merged_data[slot_in*PIXEL_WIDTH +: PIXEL_WIDTH] = data_in;
            merged_strb[slot_in]                            = 1'b1;
            fresh_data[slot_in*PIXEL_WIDTH +: PIXEL_WIDTH]  = data_in;
            fresh_strb[slot_in]                             = 1'b1;
        end
    end

    always_comb begin
        open_addr_d = open_addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        valid_d     = valid_q;
        oaddr_d     = oaddr_q;
        odata_d     = odata_q;
        ostrb_d     = ostrb_q;
        if (close) begin
            valid_d = 1'b1;
            oaddr_d = open_addr_q;
            if (new_chunk) begin
                odata_d     = data_q;
                ostrb_d     = strb_q;
                data_d      = fresh_data;
                strb_d      = fresh_strb;
                open_addr_d = chunk_in;
            end else begin
                odata_d = merged_data;
                ostrb_d = merged_strb;
                data_d  = '0;
                strb_d  = '0;
            end
        end else begin
            if (ready_in) begin
                valid_d = 1'b0;
            end
            // accept without close implies the pixel lands in the open chunk or starts one
            if (accept) begin
                if (open) begin
                    data_d = merged_data;
                    strb_d = merged_strb;
                end else begin
                    data_d      = fresh_data;
                    strb_d      = fresh_strb;
                    open_addr_d = chunk_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            open_addr_q <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            valid_q     <= 1'b0;
            oaddr_q     <= '0;
            odata_q     <= '0;
            ostrb_q     <= '0;
        end else begin
            open_addr_q <= open_addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            valid_q     <= valid_d;
            oaddr_q     <= oaddr_d;
            odata_q     <= odata_d;
            ostrb_q     <= ostrb_d;
        end
    end

    always_comb begin
        strobe_out = '0;
        for (int unsigned i = 0; i < CHUNK_PIXELS; i++) begin
            strobe_out[i*BPP +: BPP] = {BPP{ostrb_q[i]}};
        end
    end

    assign ready_out = free;
    assign valid_out = valid_q;
    assign addr_out  = oaddr_q;
    assign data_out  = odata_q;
    assign busy_out  = open || valid_q;

endmodule

// File: tb/tb_pixel_chunk_packer.sv
// Self-checking bench for pixel_chunk_packer: directed cases plus randomized traffic
// checked every cycle against a pixel-level reference model.
module tb_pixel_chunk_packer;

    localparam int CHUNK = 8;
    localparam int PW    = 16;
    localparam int NPIX  = 1280 * 720;
    localparam int IDLE  = 4;

    logic         clk = 1'b0;
    logic         rst_in = 1'b1;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic [19:0]  addr_in = '0;
    logic [15:0]  data_in = '0;
    logic         strobe_in = 1'b0;
    logic         flush_in = 1'b0;
    logic         valid_out;
    logic         ready_in = 1'b1;
    logic [16:0]  addr_out;
    logic [127:0] data_out;
    logic [15:0]  strobe_out;
    logic         busy_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pixel_chunk_packer #(.IDLE_CYCLES(IDLE)) dut (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .addr_in(addr_in), .data_in(data_in), .strobe_in(strobe_in), .flush_in(flush_in),
        .valid_out(valid_out), .ready_in(ready_in), .addr_out(addr_out),
        .data_out(data_out), .strobe_out(strobe_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    // Reference model: open chunk as pixel arrays, pending beat as pixel arrays.
    int o_data[CHUNK];
    bit o_strb[CHUNK];
    int o_addr = 0;
    bit m_valid = 1'b0;
    int m_addr = 0;
    int m_odata[CHUNK];
    bit m_ostrb[CHUNK];
    int icnt = 0;

    function automatic int open_count();
        int n = 0;
        for (int i = 0; i < CHUNK; i++) n += o_strb[i];
        return n;
    endfunction

    task automatic model_step();
        int a, ca, sl, n;
        bit free, acc, open, full, idle_t, close;
        if (rst_in) begin
            for (int i = 0; i < CHUNK; i++) begin
                o_strb[i] = 0; o_data[i] = 0; m_ostrb[i] = 0; m_odata[i] = 0;
            end
            m_valid = 0; m_addr = 0; icnt = 0;
            return;
        end
        a    = int'(addr_in);
        ca   = a / CHUNK;
        sl   = a % CHUNK;
        n    = open_count();
        open = (n > 0);
        full = (n == CHUNK);
        free = !m_valid || ready_in;
        acc  = valid_in && free;
`ifdef PACKER_IDLE_FLUSH_EN
        idle_t = (icnt >= IDLE);
`else
        idle_t = 1'b0;
`endif
        close = open && free && ((acc && ca != o_addr) || flush_in || full || idle_t);
        if (close) begin
            if (acc && ca == o_addr && strobe_in) begin
                o_data[sl] = int'(data_in); o_strb[sl] = 1;
            end
            m_valid = 1; m_addr = o_addr;
            for (int i = 0; i < CHUNK; i++) begin
                m_odata[i] = o_data[i]; m_ostrb[i] = o_strb[i];
                o_strb[i] = 0; o_data[i] = 0;
            end
            if (acc && ca != o_addr) begin
                o_addr = ca;
                if (strobe_in) begin o_data[sl] = int'(data_in); o_strb[sl] = 1; end
            end
        end else begin
            if (m_valid && ready_in) m_valid = 0;
            if (acc) begin
                if (!open) o_addr = ca;
                if (strobe_in) begin o_data[sl] = int'(data_in); o_strb[sl] = 1; end
            end
        end
        if (acc || close) icnt = 0;
        else if (open) icnt++;
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [15:0] es;
            bit dbad;
            chk("ready_out", ready_out, !m_valid || ready_in);
            chk("valid_out", valid_out, m_valid);
            chk("busy_out", busy_out, m_valid || (open_count() > 0));
            if (m_valid) begin
                es = '0;
                dbad = 0;
                for (int i = 0; i < CHUNK; i++) begin
                    if (m_ostrb[i]) begin
                        es[2*i +: 2] = 2'b11;
                        if (data_out[i*PW +: PW] !== m_odata[i][15:0]) dbad = 1;
                    end
                end
                chk("addr_out", addr_out, m_addr[16:0]);
                chk("strobe_out", strobe_out, es);
                chk("data_out_strobed", dbad, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int a, input int d, input bit s);
        valid_in = 1; addr_in = a[19:0]; data_in = d[15:0]; strobe_in = s; flush_in = 0;
        step();
        valid_in = 0;
    endtask

    task automatic idle(input int n);
        valid_in = 0; flush_in = 0;
        repeat (n) step();
    endtask

    task automatic flush();
        valid_in = 0; flush_in = 1;
        step();
        flush_in = 0;
    endtask

    initial begin
        int last_a = 0;
        step();
        chk_en = 1;
        step();
        rst_in = 0;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_addr", addr_out, 17'd0);
        chk("rst_data", data_out, 128'd0);
        chk("rst_strobe", strobe_out, 16'd0);
        chk("rst_busy", busy_out, 1'b0);

        // full chunk closes one cycle after the eighth pixel
        for (int i = 0; i < 8; i++) px(i, i, 1);
        chk("full_not_yet", valid_out, 1'b0);
        idle(1);
        chk("full_valid", valid_out, 1'b1);
        chk("full_addr", addr_out, 17'd0);
        chk("full_strobe", strobe_out, 16'hFFFF);
        chk("full_data", data_out, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        idle(1);

        // new-chunk close, then flush of the remaining pixel
        px(3, 16'h1111, 1);
        px(17, 16'h2222, 1);
        chk("nc_addr", addr_out, 17'd0);
        chk("nc_strobe", strobe_out, 16'h00C0);
        flush();
        chk("fl_addr", addr_out, 17'd2);
        chk("fl_strobe", strobe_out, 16'h000C);
        chk("fl_data", data_out[31:16], 16'h2222);
        idle(1);

        // backpressure across two closes
        ready_in = 0;
        px(40, 16'h4040, 1);
        px(48, 16'h4848, 1);
        chk("bp_ready", ready_out, 1'b0);
        valid_in = 1; addr_in = 20'd49; data_in = 16'h4949; strobe_in = 1;
        repeat (3) begin
            step();
            chk("bp_hold_addr", addr_out, 17'd5);
        end
        valid_in = 0;
        ready_in = 1;
        flush();
        chk("bp_b2b_valid", valid_out, 1'b1);
        chk("bp_b2b_addr", addr_out, 17'd6);
        idle(1);

        // same-slot overwrite, then strobe-0 only
        px(5, 16'hAAAA, 1);
        px(5, 16'hBBBB, 1);
        flush();
        chk("ow_data", data_out[95:80], 16'hBBBB);
        chk("ow_strobe", strobe_out, 16'h0C00);
        idle(1);
        px(9, 16'h9999, 0);
        flush();
        idle(2);
        chk("s0_valid", valid_out, 1'b0);
        chk("s0_busy", busy_out, 1'b0);

        // reset with a pending beat and an open chunk
        px(80, 1, 1); px(81, 2, 1); px(82, 3, 1);
        ready_in = 0;
        px(88, 4, 1);
        chk("prerst_valid", valid_out, 1'b1);
        rst_in = 1;
        step();
        rst_in = 0;
        chk("mrst_valid", valid_out, 1'b0);
        chk("mrst_busy", busy_out, 1'b0);
        ready_in = 1;
        flush();
        idle(2);
        chk("mrst_flush_noop", valid_out, 1'b0);

        // idle behaviour
        px(100, 16'hC0DE, 1);
`ifdef PACKER_IDLE_FLUSH_EN
        idle(4);
        chk("idle_not_yet", valid_out, 1'b0);
        idle(1);
        chk("idle_valid", valid_out, 1'b1);
        chk("idle_addr", addr_out, 17'd12);
        idle(1);
`else
        idle(20);
        chk("noidle_valid", valid_out, 1'b0);
        chk("noidle_busy", busy_out, 1'b1);
        flush();
        chk("noidle_flush_addr", addr_out, 17'd12);
        idle(1);
`endif

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r, a;
            r = int'($urandom_range(0, 99));
            if (r < 50) a = (last_a + 1) % NPIX;
            else if (r < 92) a = int'($urandom_range(0, 63));
            else a = int'($urandom_range(0, NPIX - 1));
            valid_in  = ($urandom_range(0, 99) < 70);
            addr_in   = a[19:0];
            data_in   = 16'($urandom);
            strobe_in = ($urandom_range(0, 99) < 85);
            flush_in  = ($urandom_range(0, 99) < 5);
            ready_in  = ($urandom_range(0, 99) < 70);
            rst_in    = ($urandom_range(0, 399) == 0);
            if (valid_in && ready_out) last_a = a;
            step();
        end
        rst_in = 0; ready_in = 1;
        flush();
        idle(3);
        chk("end_busy", busy_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
